sys_rst_ctrl: RTL
=================

SYS_RST_CTRL -- requirements
Module: sys_rst_ctrl

Interface
REQ-001 SHALL provide parameter NUM_RST, default 4, number of independent reset outputs (1..16).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 100000, stable-low cycles required for a button press.
REQ-003 SHALL provide parameter HOLD_CYCLES, default 16, minimum all-asserted cycles in HOLD.
REQ-004 SHALL provide parameter STAGGER_CYCLES, default 8, spacing between successive channel releases.
REQ-005 SHALL provide parameter WDT_CYCLES, default 2^24, watchdog timeout.
REQ-006 SHALL have port clk_i  input  1  system clock; sole clock.
REQ-007 SHALL have port rst_i  input  1  synchronous active-high reset (power-on).
REQ-008 SHALL have port btn_n_i  input  1  raw asynchronous reset button, active-low.
REQ-009 SHALL have port sw_rst_i  input  1  single-cycle software reset request.
REQ-010 SHALL have port wdt_kick_i  input  1  watchdog kick pulse.
REQ-011 SHALL have port rst_o  output  NUM_RST  per-domain active-high resets; bit 0 released first.
REQ-012 SHALL have port ready_o  output  1  high when all domains released.
REQ-013 SHALL have port cause_o  output  2  last reset cause: 0 POR, 1 button, 2 software, 3 watchdog.
REQ-014 SHALL have port rst_cnt_o  output  8  count of non-POR resets, saturating at 255.
REQ-015 Clock is one clock, clk_i; reset rst_i is synchronous and active-high.

Function
REQ-016 btn_n_i SHALL pass a 2-flop synchronizer; debounce counter increments each cycle synced value is low, clears when high.
REQ-017 Press event SHALL fire once when debounce counter reaches DEBOUNCE_CYCLES; rst_o all-ones on next edge (btn fall to rst_o = 2+DEBOUNCE_CYCLES+1 cycles).
REQ-018 FSM states SHALL be HOLD, RELEASE, RUN.
REQ-019 HOLD: rst_o all ones, ready_o 0; hold counter advances only while debounced button is not pressed; exit to RELEASE when counter reaches HOLD_CYCLES.
REQ-020 Entering RELEASE SHALL deassert rst_o[0] on the same edge; rst_o[k] SHALL deassert STAGGER_CYCLES cycles after rst_o[k-1]; released bits stay low.
REQ-021 After rst_o[NUM_RST-1] deasserts, FSM SHALL enter RUN and assert ready_o on the next edge.
REQ-022 In RELEASE or RUN, any trigger (press, sw_rst_i, watchdog expiry) SHALL return FSM to HOLD with rst_o all ones on next edge and counters cleared.
REQ-023 Simultaneous triggers SHALL record cause with priority button > watchdog > software.
REQ-024 sw_rst_i and watchdog SHALL be ignored in HOLD; a press in HOLD extends HOLD and updates cause to 1.
REQ-025 rst_cnt_o SHALL increment by one per trigger accepted in RELEASE/RUN, saturate at 255.
REQ-026 Counter widths SHALL be $clog2(max value + 1); no wrap-around of any counter.

Reset
REQ-027 On rst_i: FSM = HOLD, rst_o all ones, ready_o 0, cause_o 0, rst_cnt_o 0, synchronizer flops 1, all counters 0.
REQ-028 rst_i asserted mid-RELEASE or RUN SHALL override all triggers and take effect on the next edge.

Configuration
REQ-029 Macro MIPS_RSTCTRL_WDT_EN SHALL compile in the watchdog: counter increments in RUN, clears on wdt_kick_i or outside RUN, trigger when it reaches WDT_CYCLES-1 without kick; kick in expiry cycle wins.
REQ-030 Without MIPS_RSTCTRL_WDT_EN, no watchdog logic, wdt_kick_i ignored, cause_o never 3.

Verification (NUM_RST=3, DEBOUNCE_CYCLES=8, HOLD_CYCLES=4, STAGGER_CYCLES=2, WDT_CYCLES=32)
REQ-031 rst_i high 3 cycles, low at edge 0 -> rst_o 111 until edge 4, 110 at 4, 100 at 6, 000 at 8, ready_o 1 at 9, cause_o 0.
REQ-032 In RUN, btn_n_i low 5 cycles then high -> no reset, rst_o 000; btn_n_i low 20 cycles -> rst_o 111 exactly 11 cycles after fall, held until 4 cycles after debounced release, cause_o 1, rst_cnt_o 1.
REQ-033 In RUN, sw_rst_i and press event same cycle -> rst_o 111 next edge, cause_o 1, rst_cnt_o +1 only.
REQ-034 WDT_EN: no kick for 32 cycles in RUN -> rst_o 111, cause_o 3; kick every 20 cycles -> never resets; without macro -> never resets.
REQ-035 sw_rst_i pulsed while rst_o = 100 -> rst_o 111 next edge, full release sequence repeats; 300 software resets -> rst_cnt_o 255.
REQ-036 rst_i pulsed in RUN with cause_o 2, rst_cnt_o 7 -> cause_o 0, rst_cnt_o 0, rst_o 111 next edge.

Source files
------------

// File: rtl/sys_rst_ctrl.sv
// Reset sequencer: debounced button, software and watchdog triggers; staggered release of NUM_RST domains.
// Latency: button fall to rst_o asserted = DEBOUNCE_CYCLES+3 edges; software/watchdog trigger asserts on the next edge.
// No backpressure. Build with MIPS_RSTCTRL_WDT_EN defined to include the watchdog.
module sys_rst_ctrl #(
    parameter int NUM_RST         = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 8,
    parameter int WDT_CYCLES      = 1 << 24
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               btn_n_i,
    input  logic               sw_rst_i,
    input  logic               wdt_kick_i,
    output logic [NUM_RST-1:0] rst_o,
    output logic               ready_o,
    output logic [1:0]         cause_o,
    output logic [7:0]         rst_cnt_o
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STAG_W = $clog2(STAGGER_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_MAX = STAG_W'(STAGGER_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         btn_sync;
    logic [DEB_W-1:0]   deb_cnt;
    logic               pressed_q;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [STAG_W-1:0]  stag_cnt;
    logic               btn_pressed;
    logic               press_evt;
    logic               wdt_exp;
    logic               trigger;

    assign btn_pressed = (deb_cnt == DEB_MAX);
    // Single-cycle pulse on the first cycle the debounce count saturates.
    assign press_evt   = btn_pressed && !pressed_q;
    assign trigger     = press_evt || wdt_exp || sw_rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_sync  <= 2'b11;
            deb_cnt   <= '0;
            pressed_q <= 1'b0;
        end else begin
            btn_sync  <= {btn_sync[0], btn_n_i};
            pressed_q <= btn_pressed;
            if (btn_sync[1]) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

`ifdef MIPS_RSTCTRL_WDT_EN
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;

    // A kick in the expiry cycle suppresses the trigger.
    assign wdt_exp = (state == S_RUN) && (wdt_cnt == WDT_MAX) && !wdt_kick_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdt_cnt <= '0;
        end else if (state != S_RUN || wdt_kick_i || wdt_exp) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end
`else
    logic unused_kick;
    assign unused_kick = wdt_kick_i;
    assign wdt_exp     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_HOLD;
            rst_o     <= '1;
            ready_o   <= 1'b0;
            cause_o   <= 2'd0;
            rst_cnt_o <= 8'd0;
            hold_cnt  <= '0;
            stag_cnt  <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (press_evt) begin
                        cause_o  <= 2'd1;
                        hold_cnt <= '0;
                    end else if (!btn_pressed) begin
                        if (hold_cnt == HOLD_MAX) begin
                            state    <= S_RELEASE;
                            rst_o    <= rst_o << 1;
                            hold_cnt <= '0;
                            stag_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (trigger) begin
                        state    <= S_HOLD;
                        rst_o    <= '1;
                        ready_o  <= 1'b0;
                        hold_cnt <= '0;
                        stag_cnt <= '0;
                        if (press_evt) begin
                            cause_o <= 2'd1;
                        end else if (wdt_exp) begin
                            cause_o <= 2'd3;
                        end else begin
                            cause_o <= 2'd2;
                        end
                        if (rst_cnt_o != 8'hFF) begin
                            rst_cnt_o <= rst_cnt_o + 1'b1;
                        end
                    end else if (state == S_RELEASE) begin
                        // Zeros shift in from bit 0, so domains release in index order.
                        if (rst_o == '0) begin
                            state   <= S_RUN;
                            ready_o <= 1'b1;
                        end else if (stag_cnt == STAG_MAX) begin
                            rst_o    <= rst_o << 1;
                            stag_cnt <= '0;
                        end else begin
                            stag_cnt <= stag_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
